// File: rtl/reg_writeback_unit.sv
// Writeback stage feeding the register file write port (regWrite/Addr3/dataIn).
// Ports: ALU and load requests (valid/ready), wb_hold, rf_* write port, ld_err,
// wb_pending, rsN bypass lookup; bypass forwarding enabled by WB_BYPASS_EN.
module reg_writeback_unit #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [4:0]    ld_rd,
  input  logic [2:0]    ld_funct3,
  input  logic [1:0]    ld_addr_lo,
  input  logic [31:0]   ld_word,
  input  logic          wb_hold,
  output logic          rf_we,
  output logic [4:0]    rf_waddr,
  output logic [31:0]   rf_wdata,
  output logic          ld_err,
  output logic [CW-1:0] wb_pending,
  input  logic [4:0]    rs1_addr,
  input  logic [4:0]    rs2_addr,
  output logic          rs1_fwd_valid,
  output logic          rs2_fwd_valid,
  output logic [31:0]   rs1_fwd_data,
  output logic [31:0]   rs2_fwd_data
);

  // Shift-register FIFO: slot 0 is the head, slot count-1 the youngest.
  logic [4:0]    rd_q   [DEPTH];
  logic [4:0]    rd_d   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          rr_q, rr_d;
  logic          ld_err_q, ld_err_d;

  logic          pop, space, push;
  logic [CW-1:0] wr_idx;
  logic [4:0]    push_rd;
  logic [31:0]   push_data;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_fmt;
  logic          ld_bad;

  assign pop   = (count_q != '0) && !wb_hold;
  assign space = (count_q < CW'(DEPTH)) || pop;

  // rr_q=1 favours the load source on a contested cycle.
  assign ld_ready  = space && ld_valid && (!alu_valid || rr_q);
  assign alu_ready = space && alu_valid && (!ld_valid || !rr_q);
  assign rr_d      = (space && ld_valid && alu_valid) ? ~rr_q : rr_q;

  assign rf_we    = pop;
  assign rf_waddr = pop ? rd_q[0] : '0;
  assign rf_wdata = pop ? data_q[0] : '0;

  assign ld_err     = ld_err_q;
  assign wb_pending = count_q;

  always_comb begin
    ld_b   = ld_word[7:0];
    ld_h   = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_fmt = ld_word;
    ld_bad = 1'b0;
    unique case (ld_addr_lo)
      2'd0: ld_b = ld_word[7:0];
      2'd1: ld_b = ld_word[15:8];
      2'd2: ld_b = ld_word[23:16];
      2'd3: ld_b = ld_word[31:24];
    endcase
    unique case (ld_funct3)
      3'b000: ld_fmt = {{24{ld_b[7]}}, ld_b};
      3'b001: ld_fmt = {{16{ld_h[15]}}, ld_h};
      3'b010: ld_fmt = ld_word;
      3'b100: ld_fmt = {24'd0, ld_b};
      3'b101: ld_fmt = {16'd0, ld_h};
      default: begin
        ld_fmt = ld_word;
        ld_bad = 1'b1;
      end
    endcase
  end

  assign ld_err_d  = ld_ready && ld_bad;
  assign push_rd   = ld_ready ? ld_rd : alu_rd;
  assign push_data = ld_ready ? ld_fmt : alu_data;
  // x0 writes are acknowledged but never stored.
  assign push      = (ld_ready || alu_ready) && (push_rd != 5'd0);
  assign wr_idx    = pop ? count_q - CW'(1) : count_q;

  always_comb begin
    rd_d    = rd_q;
    data_d  = data_q;
    count_d = count_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        rd_d[i]   = rd_q[i+1];
        data_d[i] = data_q[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) begin
          rd_d[i]   = push_rd;
          data_d[i] = push_data;
        end
      end
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      rr_q     <= 1'b1;
      ld_err_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rr_q     <= rr_d;
      ld_err_q <= ld_err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      rd_q[i]   <= rd_d[i];
      data_q[i] <= data_d[i];
    end
  end

`ifdef WB_BYPASS_EN
  // Later slots are younger, so the last hit in the scan wins.
  always_comb begin
    rs1_fwd_valid = 1'b0;
    rs2_fwd_valid = 1'b0;
    rs1_fwd_data  = '0;
    rs2_fwd_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (rs1_addr != 5'd0 && rd_q[i] == rs1_addr) begin
          rs1_fwd_valid = 1'b1;
          rs1_fwd_data  = data_q[i];
        end
        if (rs2_addr != 5'd0 && rd_q[i] == rs2_addr) begin
          rs2_fwd_valid = 1'b1;
          rs2_fwd_data  = data_q[i];
        end
      end
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{rs1_addr, rs2_addr};
  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd_data  = '0;
  assign rs2_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed-vector bench for reg_writeback_unit (DEPTH=2).
// Covers reset, ALU/load paths, arbitration, hold, x0, reset flush, bypass.
module tb_reg_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_word;
  logic        wb_hold;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ld_err;
  logic [1:0]  wb_pending;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_fwd_valid, rs2_fwd_valid;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_writeback_unit #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_rd(ld_rd), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .ld_word(ld_word),
    .wb_hold(wb_hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ld_err(ld_err), .wb_pending(wb_pending),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load vectors: funct3, offset, expected data, expected ld_err
  logic [2:0]  lv_f3  [8] = '{3'b000, 3'b000, 3'b101, 3'b001,
                              3'b011, 3'b100, 3'b001, 3'b001};
  logic [1:0]  lv_off [8] = '{2'd1, 2'd3, 2'd2, 2'd0,
                              2'd0, 2'd2, 2'd2, 2'd3};
  logic [31:0] lv_exp [8] = '{32'h0000007F, 32'hFFFFFF80, 32'h000080F1,
                              32'h00007F02, 32'h80F17F02, 32'h000000F1,
                              32'hFFFF80F1, 32'hFFFF80F1};
  logic        lv_err [8] = '{1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    logic [4:0] ld_rds [2];
    logic [4:0] alu_rds [2];
    logic       exp_l [4];
    logic [4:0] prev_rd;
    int li, ai;
    ld_rds  = '{5'd10, 5'd11};
    alu_rds = '{5'd20, 5'd21};
    exp_l   = '{1'b1, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0; ld_word = 0;
    wb_hold = 0; rs1_addr = 0; rs2_addr = 0;
    tick();
    tick();
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_waddr", 32'(rf_waddr), 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_lderr", 32'(ld_err), 0);
    chk("rst_pend", 32'(wb_pending), 0);
    chk("rst_fwd1", 32'(rs1_fwd_valid), 0);
    chk("rst_fwd2d", rs2_fwd_data, 0);
    reset = 1'b0;

    // ALU single write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    chk("alu_rdy", 32'(alu_ready), 1);
    chk("alu_ldrdy", 32'(ld_ready), 0);
    tick();
    alu_valid = 0;
    #1;
    chk("alu_we", 32'(rf_we), 1);
    chk("alu_waddr", 32'(rf_waddr), 5);
    chk("alu_wdata", rf_wdata, 32'hDEADBEEF);
    chk("alu_pend1", 32'(wb_pending), 1);
    tick();
    chk("alu_pend0", 32'(wb_pending), 0);
    chk("alu_we0", 32'(rf_we), 0);

    // Load formatting
    for (int k = 0; k < 8; k++) begin
      ld_valid = 1; ld_rd = 8; ld_word = 32'h80F17F02;
      ld_funct3 = lv_f3[k]; ld_addr_lo = lv_off[k];
      #1;
      chk("ld_rdy", 32'(ld_ready), 1);
      tick();
      ld_valid = 0;
      #1;
      chk("ld_we", 32'(rf_we), 1);
      chk("ld_data", rf_wdata, lv_exp[k]);
      chk("ld_err", 32'(ld_err), 32'(lv_err[k]));
      tick();
      chk("ld_err_clr", 32'(ld_err), 0);
    end

    // Contested arbitration L,A,L,A
    li = 0; ai = 0; prev_rd = 0;
    ld_funct3 = 3'b010; ld_addr_lo = 0;
    ld_valid = 1; ld_rd = ld_rds[0]; ld_word = 32'h0000000A;
    alu_valid = 1; alu_rd = alu_rds[0]; alu_data = 32'h00000014;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("arb_ld", 32'(ld_ready), 32'(exp_l[k]));
      chk("arb_alu", 32'(alu_ready), 32'(!exp_l[k]));
      if (k > 0) chk("arb_wa", 32'(rf_waddr), 32'(prev_rd));
      tick();
      if (exp_l[k]) begin
        prev_rd = ld_rds[li];
        li++;
        if (li < 2) ld_rd = ld_rds[li]; else ld_valid = 0;
      end else begin
        prev_rd = alu_rds[ai];
        ai++;
        if (ai < 2) alu_rd = alu_rds[ai]; else alu_valid = 0;
      end
    end
    ld_valid = 0; alu_valid = 0;
    #1;
    chk("arb_last", 32'(rf_waddr), 21);
    tick();
    chk("arb_idle", 32'(rf_we), 0);

    // Hold fills FIFO; third request blocked
    wb_hold = 1;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    #1;
    chk("hold_r1", 32'(alu_ready), 1);
    tick();
    alu_rd = 2; alu_data = 32'h22;
    #1;
    chk("hold_r2", 32'(alu_ready), 1);
    chk("hold_we", 32'(rf_we), 0);
    tick();
    alu_rd = 3; alu_data = 32'h33;
    #1;
    chk("hold_r3", 32'(alu_ready), 0);
    chk("hold_pend", 32'(wb_pending), 2);
    tick();
    chk("hold_r3b", 32'(alu_ready), 0);
    wb_hold = 0;
    #1;
    chk("rel_we1", 32'(rf_we), 1);
    chk("rel_wa1", 32'(rf_waddr), 1);
    chk("rel_r3", 32'(alu_ready), 1);
    tick();
    alu_valid = 0;
    #1;
    chk("rel_wa2", 32'(rf_waddr), 2);
    chk("rel_pend", 32'(wb_pending), 2);
    tick();
    chk("rel_wa3", 32'(rf_waddr), 3);
    chk("rel_wd3", rf_wdata, 32'h33);
    tick();
    chk("rel_pend0", 32'(wb_pending), 0);

    // x0 destination
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
    #1;
    chk("x0_rdy", 32'(alu_ready), 1);
    tick();
    alu_valid = 0;
    #1;
    chk("x0_we", 32'(rf_we), 0);
    chk("x0_pend", 32'(wb_pending), 0);

    // Bypass lookup with two rd=7 entries held
    wb_hold = 1;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h1;
    tick();
    alu_data = 32'h2;
    tick();
    alu_valid = 0; rs1_addr = 7; rs2_addr = 0;
    #1;
    chk("byp_pend", 32'(wb_pending), 2);
`ifdef WB_BYPASS_EN
    chk("byp_v1", 32'(rs1_fwd_valid), 1);
    chk("byp_d1", rs1_fwd_data, 32'h2);
`else
    chk("byp_v1", 32'(rs1_fwd_valid), 0);
    chk("byp_d1", rs1_fwd_data, 0);
`endif
    chk("byp_v2", 32'(rs2_fwd_valid), 0);
    chk("byp_d2", rs2_fwd_data, 0);

    // Reset flushes pending entries
    reset = 1; wb_hold = 0;
    tick();
    chk("flush_we", 32'(rf_we), 0);
    chk("flush_pend", 32'(wb_pending), 0);
    reset = 0;
    #1;
    chk("flush_we2", 32'(rf_we), 0);
    chk("flush_fwd", 32'(rs1_fwd_valid), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
